if_stage: RTL and testbench

- Instruction-fetch stage: PC register, single-outstanding instruction-memory request/response handshake, one-entry hold buffer, and the IF/ID pipeline register.
- Sits directly upstream of decode and the hazard unit. Consumes pc_write, if_id_write and if_id_flush from the hazard unit, and the taken-branch/jump redirect from EX/MEM.
- Produces if_id_rs1, if_id_rs2 and if_id_opcode, which feed the hazard unit.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/if_id_reg.sv | 33 +++
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 constants, opcode encodings and fetch-state encoding
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with write-enable, flush-to-bubble, async reset
// Ports: clk, rst; en (write), flush; d_valid/d_pc/d_instr in; q_valid/q_pc/q_instr out.
// A bubble (flush, or a write with nothing valid to deliver) clears valid and
// loads NOP_INSTR; the pc field is left as-is since it is meaningless for a bubble.
module if_id_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_pc,
  input  logic [31:0]     d_instr,
  output logic            q_valid,
  output logic [XLEN-1:0] q_pc,
  output logic [31:0]     q_instr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_instr <= NOP_INSTR;
    end else if (flush || (en && !d_valid)) begin
      q_valid <= 1'b0;
      q_instr <= NOP_INSTR;
    end else if (en) begin
      q_valid <= 1'b1;
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch - PC, single-outstanding imem handshake, hold buffer, IF/ID
// Ports: hazard controls (pc_write, if_id_write, if_id_flush), redirect_valid/redirect_pc,
// imem_req/imem_addr out, imem_rvalid/imem_rdata in, IF/ID outputs with decode slices,
// fetch_busy. Optional macro IF_MISALIGN_CHECK_EN adds if_misaligned and halts fetch
// after a misaligned redirect; without it redirect_pc[1:0] is forced to 00.
// imem_req/imem_addr are Mealy outputs so a response and the next request can share a
// cycle, giving one instruction per cycle with a latency-1 memory.
module if_stage #(
  parameter int            XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            if_id_flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr,
  output logic [6:0]      if_id_opcode,
  output logic [4:0]      if_id_rs1,
  output logic [4:0]      if_id_rs2,
`ifdef IF_MISALIGN_CHECK_EN
  output logic            if_misaligned,
`endif
  output logic            fetch_busy
);
  import riscv_pkg::*;
  fetch_state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n, pc_plus4, rpc;
  logic [31:0] hold_instr;
  logic req, deliver, hold_ld, ok, mis;
`ifdef IF_MISALIGN_CHECK_EN
  assign rpc = redirect_pc;
  assign if_misaligned = mis;
  always_ff @(posedge clk or posedge rst)
    if (rst) mis <= 1'b0;
    else if (redirect_valid) mis <= |redirect_pc[1:0];
`else
  assign mis = 1'b0;
  assign rpc = redirect_pc & ~XLEN'(3);
`endif
  assign ok = if_id_write && !if_id_flush;
  assign pc_plus4 = pc + XLEN'(4);
  always_comb begin
    state_n = state;
    pc_n = pc;
    req = 1'b0;
    deliver = 1'b0;
    hold_ld = 1'b0;
    if (redirect_valid) begin
      pc_n = rpc;
      state_n = ((state == WAIT || state == DROP) && !imem_rvalid) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: begin
          req = pc_write && !mis;
          state_n = req ? WAIT : IDLE;
        end
        WAIT: begin
          deliver = imem_rvalid && ok;
          hold_ld = imem_rvalid && !ok;
          state_n = hold_ld ? HOLD : WAIT;
        end
        HOLD: deliver = ok;
        DROP: state_n = imem_rvalid ? IDLE : DROP;
        default: state_n = IDLE;
      endcase
      if (deliver) begin
        pc_n = pc_plus4;
        req = pc_write;
        state_n = pc_write ? WAIT : IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (hold_ld) hold_instr <= imem_rdata;
    end
  assign imem_req = req && !rst;
  assign imem_addr = deliver ? pc_plus4 : pc;
  assign fetch_busy = state == WAIT || state == DROP;
  if_id_reg #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(clk),
    .rst(rst),
    .en(if_id_write),
    .flush(if_id_flush),
    .d_valid(deliver),
    .d_pc(pc),
    .d_instr(state == HOLD ? hold_instr : imem_rdata),
    .q_valid(if_id_valid),
    .q_pc(if_id_pc),
    .q_instr(if_id_instr)
  );
  assign if_id_pc_plus4 = if_id_pc + XLEN'(4);
  assign if_id_opcode = if_id_instr[6:0];
  assign if_id_rs1 = if_id_instr[19:15];
  assign if_id_rs2 = if_id_instr[24:20];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus hand-written sequences for if_stage
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, pc_write, if_id_write, if_id_flush, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_id_pc, if_id_pc_plus4, if_id_instr;
  logic imem_req, imem_rvalid, if_id_valid, fetch_busy;
  logic [6:0] if_id_opcode;
  logic [4:0] if_id_rs1, if_id_rs2;
`ifdef IF_MISALIGN_CHECK_EN
  logic if_misaligned;
`endif
  int passed = 0, total = 0, vec_id = 0;
  int lat = 1, cnt = 0;
  logic [31:0] raddr = '0;
  logic [31:0] rb;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
`ifdef IF_MISALIGN_CHECK_EN
    .if_misaligned(if_misaligned),
`endif
    .fetch_busy(fetch_busy)
  );

  function automatic logic [31:0] w(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h0010_8113 : {a[19:0], 12'h233};
  endfunction

  // memory: answers the last request lat cycles later; not reset with the DUT
  always @(posedge clk) begin
    if (imem_req) begin
      cnt <= lat;
      raddr <= imem_addr;
    end else if (cnt > 0) cnt <= cnt - 1;
  end
  assign imem_rvalid = (cnt == 1);
  assign imem_rdata = w(raddr);

  typedef struct {
    logic pw, iw, fl, rv;
    logic [31:0] rpc;
    int lat;
    logic req;
    logic [31:0] addr;
    logic busy, valid;
    logic [31:0] ipc, instr;
  } vec_t;

  function automatic vec_t mk(input logic pw, iw, fl, rv, input logic [31:0] rpc, input int l,
                              input logic req, input logic [31:0] addr, input logic busy, valid,
                              input logic [31:0] ipc, instr);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.rv = rv; v.rpc = rpc; v.lat = l;
    v.req = req; v.addr = addr; v.busy = busy; v.valid = valid; v.ipc = ipc; v.instr = instr;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s (step %0d): got %h, want %h", n, vec_id, a, e);
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    pc_write = v.pw; if_id_write = v.iw; if_id_flush = v.fl;
    redirect_valid = v.rv; redirect_pc = v.rpc; lat = v.lat;
    #1;
    chk("imem_req", 32'(imem_req), 32'(v.req));
    chk("imem_addr", imem_addr, v.addr);
    chk("fetch_busy", 32'(fetch_busy), 32'(v.busy));
    chk("if_id_valid", 32'(if_id_valid), 32'(v.valid));
    chk("if_id_instr", if_id_instr, v.instr);
    chk("if_id_opcode", 32'(if_id_opcode), 32'(v.instr[6:0]));
    chk("if_id_rs1", 32'(if_id_rs1), 32'(v.instr[19:15]));
    chk("if_id_rs2", 32'(if_id_rs2), 32'(v.instr[24:20]));
    if (v.valid) begin
      chk("if_id_pc", if_id_pc, v.ipc);
      chk("if_id_pc_plus4", if_id_pc_plus4, v.ipc + 32'd4);
    end
    vec_id++;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; pc_write = 1'b1; if_id_write = 1'b0; if_id_flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst imem_req", 32'(imem_req), 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst if_id_valid", 32'(if_id_valid), 32'h0);
    chk("rst if_id_instr", if_id_instr, NOP);
    chk("rst if_id_pc", if_id_pc, 32'h0);
    chk("rst if_id_pc_plus4", if_id_pc_plus4, 32'h4);
    chk("rst fetch_busy", 32'(fetch_busy), 32'h0);
    chk("rst opcode", 32'(if_id_opcode), 32'h13);
    rst = 1'b0; pc_write = 1'b0;
    // steady run, latency 1
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h0,0, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h4,1, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h8,1, 1,32'h0,w(32'h0)));
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'hC,1, 1,32'h4,w(32'h4)));
    // stall while the response for 0xC returns
    tbl.push_back(mk(0,0,0,0,0,1, 0,32'hC,1, 1,32'h8,w(32'h8)));
    tbl.push_back(mk(0,0,0,0,0,1, 0,32'hC,0, 1,32'h8,w(32'h8)));
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h10,0, 1,32'h8,w(32'h8)));
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h14,1, 1,32'hC,w(32'hC)));
    tbl.push_back(mk(0,1,0,0,0,1, 0,32'h18,1, 1,32'h10,w(32'h10)));
    // redirect with a latency-3 fetch in flight
    tbl.push_back(mk(1,1,0,0,0,3, 1,32'h18,0, 1,32'h14,w(32'h14)));
    tbl.push_back(mk(1,1,1,1,32'h100,3, 0,32'h18,1, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,3, 0,32'h100,1, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,3, 0,32'h100,1, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,3, 1,32'h100,0, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,3, 0,32'h100,1, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,3, 0,32'h100,1, 0,0,NOP));
    tbl.push_back(mk(0,1,0,0,0,3, 0,32'h104,1, 0,0,NOP));
    tbl.push_back(mk(0,0,0,0,0,1, 0,32'h104,0, 1,32'h100,w(32'h100)));
    // flush beats write; word kept in hold buffer
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h104,0, 1,32'h100,w(32'h100)));
    tbl.push_back(mk(1,1,1,0,0,1, 0,32'h104,1, 0,0,NOP));
    tbl.push_back(mk(0,1,0,0,0,1, 0,32'h108,0, 0,0,NOP));
    tbl.push_back(mk(0,0,0,0,0,1, 0,32'h108,0, 1,32'h104,w(32'h104)));
    // flush plus redirect discards the word; wrap-around fetch
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h108,0, 1,32'h104,w(32'h104)));
    tbl.push_back(mk(1,1,1,1,32'hFFFF_FFFC,1, 0,32'h108,1, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'hFFFF_FFFC,0, 0,0,NOP));
    tbl.push_back(mk(1,1,0,0,0,1, 1,32'h0,1, 0,0,NOP));
    tbl.push_back(mk(0,1,0,0,0,1, 0,32'h4,1, 1,32'hFFFF_FFFC,w(32'hFFFF_FFFC)));
    tbl.push_back(mk(0,0,0,0,0,1, 0,32'h4,0, 1,32'h0,w(32'h0)));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
`ifdef IF_MISALIGN_CHECK_EN
    step(mk(1,1,0,1,32'h102,1, 0,32'h4,0, 1,32'h0,w(32'h0)));
    step(mk(1,1,0,0,0,1, 0,32'h102,0, 0,0,NOP));
    chk("if_misaligned set", 32'(if_misaligned), 32'h1);
    step(mk(1,1,0,1,32'h200,1, 0,32'h102,0, 0,0,NOP));
    chk("if_misaligned held", 32'(if_misaligned), 32'h1);
    step(mk(1,1,0,0,0,1, 1,32'h200,0, 0,0,NOP));
    chk("if_misaligned clear", 32'(if_misaligned), 32'h0);
    step(mk(0,1,0,0,0,1, 0,32'h204,1, 0,0,NOP));
    step(mk(0,0,0,0,0,1, 0,32'h204,0, 1,32'h200,w(32'h200)));
    rb = 32'h204;
`else
    step(mk(1,1,0,1,32'h102,1, 0,32'h4,0, 1,32'h0,w(32'h0)));
    step(mk(1,1,0,0,0,1, 1,32'h100,0, 0,0,NOP));
    step(mk(0,1,0,0,0,1, 0,32'h104,1, 0,0,NOP));
    step(mk(0,0,0,0,0,1, 0,32'h104,0, 1,32'h100,w(32'h100)));
    rb = 32'h104;
`endif
    // reset with a request outstanding; the late response must be ignored
    step(mk(1,1,0,0,0,2, 1,rb,0, 1,rb - 32'd4,w(rb - 32'd4)));
    @(negedge clk);
    pc_write = 1'b0; rst = 1'b1;
    #1;
    chk("midrst fetch_busy", 32'(fetch_busy), 32'h0);
    chk("midrst imem_req", 32'(imem_req), 32'h0);
    chk("midrst imem_addr", imem_addr, 32'h0);
    chk("midrst if_id_valid", 32'(if_id_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("late rsp fetch_busy", 32'(fetch_busy), 32'h0);
    chk("late rsp imem_req", 32'(imem_req), 32'h0);
    step(mk(1,1,0,0,0,2, 1,32'h0,0, 0,0,NOP));
    step(mk(0,1,0,0,0,2, 0,32'h0,1, 0,0,NOP));
    step(mk(0,1,0,0,0,2, 0,32'h4,1, 0,0,NOP));
    step(mk(0,0,0,0,0,2, 0,32'h4,0, 1,32'h0,w(32'h0)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
